ram_sp_port_ctrl: RTL



---
 rtl/ram_sp_port_ctrl.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/ram_sp_port_ctrl.sv
// ram_sp_port_ctrl
// Initiator-side controller for a single-port, write-first block RAM with
// byte enables. Accepts a valid/ready request stream, issues RAM port cycles,
// tracks read latency with a valid shift pipe, and returns read data through a
// first-word-fall-through response FIFO. Request acceptance is credit based:
// reads in flight plus queued responses never exceed the FIFO depth, so a
// returning read always finds room.
// Optional feature macro: RAM_SP_PORT_CTRL_STAT_EN adds o_stat_wr_cnt and
// o_stat_rd_cnt (accepted writes / popped read responses, 16-bit wrapping).

module ram_sp_port_ctrl #(
  parameter int WORD_BIT_WIDTH = 32,
  parameter int DEPTH          = 256,
  parameter int READ_LATENCY   = 1,
  parameter int RSP_FIFO_DEPTH = 4,
  parameter int INIT_CLEAR     = 1
) (
  input  logic                        i_clk,
  input  logic                        i_async_rst_n,
  input  logic                        i_req_valid,
  output logic                        o_req_ready,
  input  logic                        i_req_we,
  input  logic [$clog2(DEPTH)-1:0]    i_req_word_addr,
  input  logic [WORD_BIT_WIDTH-1:0]   i_req_data,
  input  logic [WORD_BIT_WIDTH/8-1:0] i_req_byte_en,
  output logic                        o_rsp_valid,
  input  logic                        i_rsp_ready,
  output logic [WORD_BIT_WIDTH-1:0]   o_rsp_data,
  output logic                        o_ram_we,
  output logic [$clog2(DEPTH)-1:0]    o_ram_word_addr,
  output logic [WORD_BIT_WIDTH-1:0]   o_ram_data,
  output logic [WORD_BIT_WIDTH/8-1:0] o_ram_byte_en,
  input  logic [WORD_BIT_WIDTH-1:0]   i_ram_data,
  output logic                        o_busy
`ifdef RAM_SP_PORT_CTRL_STAT_EN
  ,
  output logic [15:0]                 o_stat_wr_cnt,
  output logic [15:0]                 o_stat_rd_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(RSP_FIFO_DEPTH);
  localparam int CW = PW + 1;

  // Reject illegal configurations at elaboration time.
  if (WORD_BIT_WIDTH < 8 || (WORD_BIT_WIDTH & (WORD_BIT_WIDTH - 1)) != 0) begin : g_bad_width
    $error("WORD_BIT_WIDTH must be a power of 2 and at least 8");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of 2 and at least 2");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("READ_LATENCY must be 1 or 2");
  end
  if (RSP_FIFO_DEPTH < READ_LATENCY + 1 || (RSP_FIFO_DEPTH & (RSP_FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo
    $error("RSP_FIFO_DEPTH must be a power of 2 and at least READ_LATENCY+1");
  end
  if (INIT_CLEAR != 0 && INIT_CLEAR != 1) begin : g_bad_init
    $error("INIT_CLEAR must be 0 or 1");
  end

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam state_t RESET_STATE = (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;

  state_t                    state_q, state_d;
  logic [AW-1:0]             init_cnt_q;
  logic [READ_LATENCY-1:0]   rd_pipe_q;
  logic [WORD_BIT_WIDTH-1:0] fifo_mem [RSP_FIFO_DEPTH];
  logic [PW-1:0]             wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]             fifo_cnt_q;
  logic [CW:0]               inflight_cnt;
  logic [CW:0]               credit_used;
  logic                      credit_ok;
  logic                      req_fire, rd_fire, fifo_push, fifo_pop;

  // Count reads still travelling through the latency pipe.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    inflight_cnt = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight_cnt = inflight_cnt + (CW + 1)'(rd_pipe_q[i]);
    end
  end

  assign credit_used = inflight_cnt + {1'b0, fifo_cnt_q};
  assign credit_ok   = credit_used < (CW + 1)'(RSP_FIFO_DEPTH);
  assign req_fire    = i_req_valid && o_req_ready;
  assign rd_fire     = req_fire && !i_req_we;
  assign fifo_push   = rd_pipe_q[READ_LATENCY-1];
  assign fifo_pop    = o_rsp_valid && i_rsp_ready;

  // State register and fill counter.
  always_ff @(posedge i_clk or negedge i_async_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!i_async_rst_n) begin
      state_q    <= RESET_STATE;
      init_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_INIT) begin
        init_cnt_q <= init_cnt_q + AW'(1);
      end
    end
  end

  // Next state plus RAM port and handshake drive.
  always_comb begin
    state_d         = state_q;
    o_req_ready     = 1'b0;
    o_ram_we        = 1'b0;
    o_ram_word_addr = '0;
    o_ram_data      = '0;
    o_ram_byte_en   = '0;
    // The port is held quiet while reset is asserted; gating on the raw reset
    // lets the first edge after release already perform the address-0 fill.
    if (i_async_rst_n) begin
      case (state_q)
        ST_INIT: begin
          o_ram_we        = 1'b1;
          o_ram_byte_en   = '1;
          o_ram_word_addr = init_cnt_q;
          if (init_cnt_q == AW'(DEPTH - 1)) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          o_req_ready     = credit_ok;
          o_ram_we        = i_req_valid && credit_ok && i_req_we;
          o_ram_word_addr = i_req_word_addr;
          o_ram_data      = i_req_data;
          o_ram_byte_en   = o_ram_we ? i_req_byte_en : '0;
        end
      endcase
    end
  end

  assign o_busy = (state_q == ST_INIT);

  // Read-valid shift pipe matching the RAM read latency.
  always_ff @(posedge i_clk or negedge i_async_rst_n) begin
    if (!i_async_rst_n) begin
      rd_pipe_q <= '0;
    end else begin
      rd_pipe_q[0] <= rd_fire;
      for (int i = 1; i < READ_LATENCY; i++) begin
        rd_pipe_q[i] <= rd_pipe_q[i-1];
      end
    end
  end

  // Response FIFO storage.
  always_ff @(posedge i_clk) begin
    // NOTE: the data array has no reset; validity comes solely from fifo_cnt_q.
    if (fifo_push) begin
      fifo_mem[wr_ptr_q] <= i_ram_data;
    end
  end

  // Response FIFO pointers and occupancy.
  always_ff @(posedge i_clk or negedge i_async_rst_n) begin
    if (!i_async_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (fifo_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (fifo_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CW'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CW'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  assign o_rsp_valid = (fifo_cnt_q != '0);
  assign o_rsp_data  = fifo_mem[rd_ptr_q];

`ifdef RAM_SP_PORT_CTRL_STAT_EN
  // Accepted-write and popped-response statistics; fill writes never handshake.
  always_ff @(posedge i_clk or negedge i_async_rst_n) begin
    if (!i_async_rst_n) begin
      o_stat_wr_cnt <= '0;
      o_stat_rd_cnt <= '0;
    end else begin
      if (req_fire && i_req_we) o_stat_wr_cnt <= o_stat_wr_cnt + 16'd1;
      if (fifo_pop)             o_stat_rd_cnt <= o_stat_rd_cnt + 16'd1;
    end
  end
`endif

endmodule
